seq_crc_gen: RTL and testbench

- Sequential (bit-serial) CRC generator subsystem.
- Latches a parallel data word on a start pulse and shifts it out MSB first, one bit per clock.
- Feeds the bit stream to two CRC engines:
  - a fixed-polynomial engine, configured by parameters;
  - a run-time-configurable engine, configured by input ports.
- Used wherever a frame checksum over a fixed-width word is needed. The two results must always agree when configured identically.

---
 rtl/crc_pkg.sv | 29 ++
 rtl/crc_dynamic.sv | 38 +++
 rtl/crc_static.sv | 37 +++
 rtl/parallel_to_serial.sv | 62 ++++++
 rtl/seq_crc_gen.sv | 62 ++++++
 tb/tb_seq_crc_gen.sv | 320 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-32/POSIX constants, serialiser state type and single-step CRC update
package crc_pkg;

  localparam int unsigned CRC_MAX_W  = 32;
  localparam int unsigned CRC32_SIZE = 32;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'h00000000;
  localparam logic [31:0] CRC32_XOR  = 32'hFFFFFFFF;

  typedef enum logic {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

  // One MSB-first step; top_bit marks the CRC width so narrower CRCs reuse the same datapath.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] crc,
    input logic [CRC_MAX_W-1:0] poly,
    input logic                 bit_in,
    input logic [CRC_MAX_W-1:0] top_bit
  );
    logic                 fb;
    logic [CRC_MAX_W-1:0] mask;
    fb       = (|(crc & top_bit)) ^ bit_in;
    mask     = top_bit | (top_bit - 1'b1);
    crc_step = ((crc << 1) ^ (fb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/crc_dynamic.sv
// rtl/crc_dynamic.sv - bit-serial CRC engine with polynomial, seed and output XOR taken from ports
module crc_dynamic
  import crc_pkg::*;
#(
  parameter int unsigned CRC_SIZE = CRC32_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                serial,
  input  logic [CRC_SIZE-1:0] init_val,
  input  logic [CRC_SIZE-1:0] poly,
  input  logic [CRC_SIZE-1:0] final_xor,
  output logic [CRC_SIZE-1:0] crc
);

  localparam logic [CRC_MAX_W-1:0] TOP_BIT = CRC_MAX_W'(1) << (CRC_SIZE - 1);

  logic [CRC_SIZE-1:0]  lfsr_q, lfsr_d;
  logic [CRC_MAX_W-1:0] step;

  always_comb begin
    step   = crc_step(CRC_MAX_W'(lfsr_q), CRC_MAX_W'(poly), serial, TOP_BIT);
    lfsr_d = enable ? step[CRC_SIZE-1:0] : lfsr_q;
  end

  // The seed is a port value, so reset loads whatever init_val holds while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= init_val;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign crc = lfsr_q ^ final_xor;

endmodule

// File: rtl/crc_static.sv
// rtl/crc_static.sv - bit-serial CRC engine with polynomial, seed and output XOR fixed by parameters
module crc_static
  import crc_pkg::*;
#(
  parameter int unsigned          CRC_SIZE    = CRC32_SIZE,
  parameter logic [CRC_SIZE-1:0]  INITIAL_VAL = CRC32_INIT,
  parameter logic [CRC_SIZE-1:0]  CRC_POLY    = CRC32_POLY,
  parameter logic [CRC_SIZE-1:0]  FINAL_XOR   = CRC32_XOR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                serial,
  output logic [CRC_SIZE-1:0] crc
);

  localparam logic [CRC_MAX_W-1:0] TOP_BIT = CRC_MAX_W'(1) << (CRC_SIZE - 1);

  logic [CRC_SIZE-1:0]  lfsr_q, lfsr_d;
  logic [CRC_MAX_W-1:0] step;

  always_comb begin
    step   = crc_step(CRC_MAX_W'(lfsr_q), CRC_MAX_W'(CRC_POLY), serial, TOP_BIT);
    lfsr_d = enable ? step[CRC_SIZE-1:0] : lfsr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= INITIAL_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign crc = lfsr_q ^ FINAL_XOR;

endmodule

// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - latches a word on start and shifts it out MSB-first chunk by chunk
module parallel_to_serial
  import crc_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 128,
  parameter int unsigned OUT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  din,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 valid
);

  localparam int unsigned NUM_CHUNKS = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS + 1);

  p2s_state_e          state_q, state_d;
  logic [IN_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      P2S_IDLE: begin
        if (start) begin
          state_d = P2S_SHIFT;
          shreg_d = din;
          cnt_d   = CNT_W'(NUM_CHUNKS);
        end
      end
      P2S_SHIFT: begin
        // The register drains to zero as it shifts, so dout idles low without gating.
        shreg_d = shreg_q << OUT_WIDTH;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = P2S_IDLE;
        end
      end
      default: state_d = P2S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= P2S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout  = shreg_q[IN_WIDTH-1 -: OUT_WIDTH];
  assign valid = (state_q == P2S_SHIFT);

endmodule

// File: rtl/seq_crc_gen.sv
// rtl/seq_crc_gen.sv - serialises a data word MSB-first into a static and a run-time-configured CRC engine
module seq_crc_gen
  import crc_pkg::*;
#(
  parameter int unsigned         CRC_SIZE    = CRC32_SIZE,
  parameter logic [CRC_SIZE-1:0] INITIAL_VAL = CRC32_INIT,
  parameter logic [CRC_SIZE-1:0] CRC_POLY    = CRC32_POLY,
  parameter logic [CRC_SIZE-1:0] FINAL_XOR   = CRC32_XOR,
  parameter int unsigned         DATA_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [CRC_SIZE-1:0]   init_val,
  input  logic [CRC_SIZE-1:0]   poly,
  input  logic [CRC_SIZE-1:0]   final_xor,
  output logic                  serial,
  output logic                  enable,
  output logic [CRC_SIZE-1:0]   crc_s,
  output logic [CRC_SIZE-1:0]   crc_d
);

  parallel_to_serial #(
    .IN_WIDTH  (DATA_WIDTH),
    .OUT_WIDTH (1)
  ) u_p2s (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (data),
    .dout  (serial),
    .valid (enable)
  );

  crc_static #(
    .CRC_SIZE    (CRC_SIZE),
    .INITIAL_VAL (INITIAL_VAL),
    .CRC_POLY    (CRC_POLY),
    .FINAL_XOR   (FINAL_XOR)
  ) u_crc_static (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .serial (serial),
    .crc    (crc_s)
  );

  crc_dynamic #(
    .CRC_SIZE (CRC_SIZE)
  ) u_crc_dynamic (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .serial    (serial),
    .init_val  (init_val),
    .poly      (poly),
    .final_xor (final_xor),
    .crc       (crc_d)
  );

endmodule

// File: tb/tb_seq_crc_gen.sv
// tb/tb_seq_crc_gen.sv - directed self-checking bench for seq_crc_gen at widths 128, 72 and 1
module tb_seq_crc_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic         start_a = 1'b0;
  logic [127:0] data_a  = '0;
  logic [31:0]  init_a  = 32'hA5A50000;
  logic [31:0]  poly_a  = 32'h04C11DB7;
  logic [31:0]  fx_a    = 32'hFFFFFFFF;
  logic         serial_a, enable_a;
  logic [31:0]  crc_s_a, crc_d_a;

  logic         start_b = 1'b0;
  logic [71:0]  data_b  = '0;
  logic [31:0]  init_b  = 32'hFFFFFFFF;
  logic [31:0]  poly_b  = 32'h04C11DB7;
  logic [31:0]  fx_b    = 32'hFFFFFFFF;
  logic         serial_b, enable_b;
  logic [31:0]  crc_s_b, crc_d_b;

  logic         start_c = 1'b0;
  logic [0:0]   data_c  = '0;
  logic [31:0]  init_c  = 32'h00000000;
  logic [31:0]  poly_c  = 32'h04C11DB7;
  logic [31:0]  fx_c    = 32'hFFFFFFFF;
  logic         serial_c, enable_c;
  logic [31:0]  crc_s_c, crc_d_c;

  seq_crc_gen u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data(data_a),
    .init_val(init_a), .poly(poly_a), .final_xor(fx_a),
    .serial(serial_a), .enable(enable_a), .crc_s(crc_s_a), .crc_d(crc_d_a)
  );

  seq_crc_gen #(
    .INITIAL_VAL(32'hFFFFFFFF), .FINAL_XOR(32'h00000000), .DATA_WIDTH(72)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b),
    .init_val(init_b), .poly(poly_b), .final_xor(fx_b),
    .serial(serial_b), .enable(enable_b), .crc_s(crc_s_b), .crc_d(crc_d_b)
  );

  seq_crc_gen #(
    .DATA_WIDTH(1)
  ) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .data(data_c),
    .init_val(init_c), .poly(poly_c), .final_xor(fx_c),
    .serial(serial_c), .enable(enable_c), .crc_s(crc_s_c), .crc_d(crc_d_c)
  );

  function automatic logic [31:0] crc_model(input logic [127:0] d, input int nbits,
                                            input logic [31:0] init, input logic [31:0] poly,
                                            input logic [31:0] fx);
    logic [31:0] c;
    logic        fb;
    c = init;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return c ^ fx;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one frame on instance A and reports enable length, serial-bit errors and engine disagreements.
  task automatic run_frame_a(input logic [127:0] d, input int restart_at,
                             output int cyc, output int sbad, output int dis);
    cyc  = 0;
    sbad = 0;
    dis  = 0;
    @(negedge clk);
    data_a  = d;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (enable_a === 1'b1 && cyc < 400) begin
      if (cyc < 128 && serial_a !== d[127 - cyc]) sbad++;
      if (crc_s_a !== crc_d_a) dis++;
      start_a = (cyc == restart_at);
      if (cyc == restart_at) data_a = ~d;
      cyc++;
      @(negedge clk);
      start_a = 1'b0;
    end
    if (crc_s_a !== crc_d_a) dis++;
  endtask

  task automatic test_reset();
    checks++;
    if (enable_a !== 1'b0) begin
      failures++; $display("FAIL reset_enable got=%b exp=0", enable_a);
    end
    checks++;
    if (serial_a !== 1'b0) begin
      failures++; $display("FAIL reset_serial got=%b exp=0", serial_a);
    end
    checks++;
    if (crc_s_a !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL reset_crc_s got=%h exp=ffffffff", crc_s_a);
    end
    checks++;
    if (crc_d_a !== 32'h5A5AFFFF) begin
      failures++; $display("FAIL reset_crc_d got=%h exp=5a5affff", crc_d_a);
    end
  endtask

  task automatic test_zero_word();
    int cyc, sbad, dis;
    apply_reset();
    run_frame_a(128'h0, -1, cyc, sbad, dis);
    checks++;
    if (cyc !== 128) begin
      failures++; $display("FAIL zero_enable_len got=%0d exp=128", cyc);
    end
    checks++;
    if (sbad !== 0) begin
      failures++; $display("FAIL zero_serial bad_bits=%0d exp=0", sbad);
    end
    checks++;
    if (crc_s_a !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL zero_crc_s got=%h exp=ffffffff", crc_s_a);
    end
    checks++;
    if (crc_d_a !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL zero_crc_d got=%h exp=ffffffff", crc_d_a);
    end
  endtask

  task automatic test_check_string();
    int cyc;
    cyc = 0;
    @(negedge clk);
    data_b  = 72'h313233343536373839;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (enable_b === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 72) begin
      failures++; $display("FAIL w72_enable_len got=%0d exp=72", cyc);
    end
    checks++;
    if (crc_s_b !== 32'h0376E6E7) begin
      failures++; $display("FAIL w72_crc_s got=%h exp=0376e6e7", crc_s_b);
    end
    checks++;
    if (crc_d_b !== 32'hFC891918) begin
      failures++; $display("FAIL w72_crc_d got=%h exp=fc891918", crc_d_b);
    end
  endtask

  task automatic test_single_bit();
    int cyc;
    cyc = 0;
    @(negedge clk);
    data_c  = 1'b1;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    checks++;
    if (serial_c !== 1'b1) begin
      failures++; $display("FAIL w1_serial got=%b exp=1", serial_c);
    end
    while (enable_c === 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 1) begin
      failures++; $display("FAIL w1_enable_len got=%0d exp=1", cyc);
    end
    checks++;
    if (crc_s_c !== 32'hFB3EE248) begin
      failures++; $display("FAIL w1_crc_s got=%h exp=fb3ee248", crc_s_c);
    end
    checks++;
    if (crc_d_c !== 32'hFB3EE248) begin
      failures++; $display("FAIL w1_crc_d got=%h exp=fb3ee248", crc_d_c);
    end
  endtask

  task automatic test_random_words();
    logic [127:0] d;
    logic [31:0]  exp;
    int cyc, sbad, dis;
    for (int n = 0; n < 6; n++) begin
      d = (n == 0) ? {128{1'b1}} : {$urandom, $urandom, $urandom, $urandom};
      exp = crc_model(d, 128, 32'h0, 32'h04C11DB7, 32'hFFFFFFFF);
      apply_reset();
      run_frame_a(d, -1, cyc, sbad, dis);
      checks++;
      if (cyc !== 128 || sbad !== 0) begin
        failures++; $display("FAIL rand%0d_frame len=%0d bad_bits=%0d exp len=128 bad_bits=0", n, cyc, sbad);
      end
      checks++;
      if (dis !== 0) begin
        failures++; $display("FAIL rand%0d_agree disagreements=%0d exp=0", n, dis);
      end
      checks++;
      if (crc_s_a !== exp) begin
        failures++; $display("FAIL rand%0d_crc_s got=%h exp=%h", n, crc_s_a, exp);
      end
      checks++;
      if (crc_d_a !== exp) begin
        failures++; $display("FAIL rand%0d_crc_d got=%h exp=%h", n, crc_d_a, exp);
      end
    end
  endtask

  task automatic test_restart_ignored();
    logic [127:0] d;
    logic [31:0]  exp;
    int cyc, sbad, dis;
    d   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    exp = crc_model(d, 128, 32'h0, 32'h04C11DB7, 32'hFFFFFFFF);
    apply_reset();
    run_frame_a(d, 40, cyc, sbad, dis);
    checks++;
    if (cyc !== 128) begin
      failures++; $display("FAIL restart_enable_len got=%0d exp=128", cyc);
    end
    checks++;
    if (sbad !== 0) begin
      failures++; $display("FAIL restart_serial bad_bits=%0d exp=0", sbad);
    end
    checks++;
    if (crc_s_a !== exp) begin
      failures++; $display("FAIL restart_crc_s got=%h exp=%h", crc_s_a, exp);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    @(negedge clk);
    data_a  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (enable_a !== 1'b1) begin
      failures++; $display("FAIL midrst_pre_enable got=%b exp=1", enable_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (enable_a !== 1'b0) begin
      failures++; $display("FAIL midrst_enable got=%b exp=0", enable_a);
    end
    checks++;
    if (crc_s_a !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL midrst_crc_s got=%h exp=ffffffff", crc_s_a);
    end
    checks++;
    if (crc_d_a !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL midrst_crc_d got=%h exp=ffffffff", crc_d_a);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dynamic_reconfig();
    logic [127:0] d;
    logic [31:0]  exp_s, exp_d;
    int cyc, sbad, dis;
    d      = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    exp_s  = crc_model(d, 128, 32'h0, 32'h04C11DB7, 32'hFFFFFFFF);
    exp_d  = crc_model(d, 128, 32'h0000FFFF, 32'h00001021, 32'h0);
    init_a = 32'h0000FFFF;
    poly_a = 32'h00001021;
    fx_a   = 32'h00000000;
    apply_reset();
    checks++;
    if (crc_d_a !== 32'h0000FFFF) begin
      failures++; $display("FAIL dyn_reset_crc_d got=%h exp=0000ffff", crc_d_a);
    end
    run_frame_a(d, -1, cyc, sbad, dis);
    checks++;
    if (crc_d_a !== exp_d) begin
      failures++; $display("FAIL dyn_crc_d got=%h exp=%h", crc_d_a, exp_d);
    end
    checks++;
    if (crc_s_a !== exp_s) begin
      failures++; $display("FAIL dyn_crc_s got=%h exp=%h", crc_s_a, exp_s);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    init_a = 32'h00000000;
    test_zero_word();
    apply_reset();
    test_check_string();
    test_single_bit();
    test_random_words();
    test_restart_ignored();
    test_reset_mid_frame();
    test_dynamic_reconfig();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
